// File: rtl/conv_bias_rd_pkg.sv
// conv_bias_rd_pkg: state encoding and default pipeline latency for the bias read controller
package conv_bias_rd_pkg;
  typedef enum logic [2:0] {IDLE, WAIT, READ, NEXT, DRAIN, DONE} state_t;
  localparam int PIPE_LATENCY_DEF = 3;
endpackage

// File: rtl/conv_bias_vld_pipe.sv
// conv_bias_vld_pipe: DEPTH-stage shift line carrying {last, valid}
module conv_bias_vld_pipe #(
  parameter int DEPTH = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] din,
  output logic [1:0] dout,
  output logic       empty
);
  logic [2*DEPTH-1:0] sr;
  always_ff @(posedge clk or posedge rst)
    if (rst) sr <= '0;
    else sr <= (2*DEPTH)'({sr, din});
  assign dout = sr[2*DEPTH-1 -: 2];
  // empty: nothing is left behind the output stage, so the line is clear once it retires
  always_comb begin
    empty = ~din[0];
    for (int i = 1; i < DEPTH; i++) if (sr[2*i-2]) empty = 1'b0;
  end
endmodule

// File: rtl/conv_bias_rd_ctrl.sv
// conv_bias_rd_ctrl: bias FIFO read sequencer over rows x channel groups.
// Define CONV_BIAS_RD_STATS_EN to add the saturating Rd_Word_Cnt output.
module conv_bias_rd_ctrl
  import conv_bias_rd_pkg::*;
#(
  parameter int CHANNEL_OUT_NUM       = 8,
  parameter int WIDTH_FEATURE_SIZE    = 12,
  parameter int WIDTH_CHANNEL_NUM_REG = 10,
  parameter int WIDTH_BIAS_ADDR       = 7,
  parameter int PIPE_LATENCY          = PIPE_LATENCY_DEF
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             Start,
  input  logic [WIDTH_FEATURE_SIZE-1:0]    Row_Num_Out_REG,
  input  logic [WIDTH_FEATURE_SIZE-1:0]    Col_Num_Out_REG,
  input  logic [WIDTH_CHANNEL_NUM_REG-1:0] Channel_Out_Num_REG,
  input  logic                             fifo_ready,
  input  logic                             M_Ready,
  output logic                             rd_en_fifo,
  output logic [WIDTH_BIAS_ADDR-1:0]       bias_addr,
  output logic                             M_Valid,
  output logic                             M_Last,
  output logic                             Busy,
  output logic                             Done
`ifdef CONV_BIAS_RD_STATS_EN
  ,output logic [31:0]                     Rd_Word_Cnt
`endif
);
  localparam logic [WIDTH_FEATURE_SIZE-1:0] ONE_F = 1;
  localparam logic [WIDTH_CHANNEL_NUM_REG-1:0] ONE_C = 1;
  state_t state, nxt;
  logic [WIDTH_FEATURE_SIZE-1:0] row_reg, col_reg, word_cnt, row_cnt;
  logic [WIDTH_CHANNEL_NUM_REG-1:0] grp_reg, grp_cnt, grp_in;
  logic start_ok, zero_cfg, last_word, last_grp, last_row, pipe_empty;
  logic [1:0] pipe_out;
  assign grp_in = Channel_Out_Num_REG >> $clog2(CHANNEL_OUT_NUM);
  assign zero_cfg = grp_in == '0 || Row_Num_Out_REG == '0 || Col_Num_Out_REG == '0;
  assign start_ok = state == IDLE && Start;
  assign last_word = word_cnt == row_reg - ONE_F;
  assign last_grp = grp_cnt == grp_reg - ONE_C;
  assign last_row = row_cnt == col_reg - ONE_F;
  assign bias_addr = WIDTH_BIAS_ADDR'(grp_cnt);
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= nxt;
  always_comb begin
    nxt = state;
    rd_en_fifo = state == READ;
    Busy = state != IDLE;
    Done = state == DONE;
    case (state)
      IDLE:    if (Start) nxt = zero_cfg ? DONE : WAIT;
      WAIT:    if (fifo_ready && M_Ready) nxt = READ;
      READ:    if (last_word) nxt = NEXT;
      NEXT:    nxt = last_grp && last_row ? DRAIN : WAIT;
      DRAIN:   if (pipe_empty) nxt = DONE;
      DONE:    nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      row_reg <= '0;
      col_reg <= '0;
      grp_reg <= '0;
      word_cnt <= '0;
      row_cnt <= '0;
      grp_cnt <= '0;
    end else if (start_ok) begin
      row_reg <= Row_Num_Out_REG;
      col_reg <= Col_Num_Out_REG;
      grp_reg <= grp_in;
      word_cnt <= '0;
      row_cnt <= '0;
      grp_cnt <= '0;
    end else begin
      if (state == READ) word_cnt <= last_word ? '0 : word_cnt + ONE_F;
      if (state == NEXT) begin
        grp_cnt <= last_grp ? '0 : grp_cnt + ONE_C;
        if (last_grp) row_cnt <= row_cnt + ONE_F;
      end
    end
  conv_bias_vld_pipe #(.DEPTH(PIPE_LATENCY)) u_pipe (
    .clk(clk),
    .rst(rst),
    .din({rd_en_fifo && last_word && last_grp && last_row, rd_en_fifo}),
    .dout(pipe_out),
    .empty(pipe_empty)
  );
  assign M_Valid = pipe_out[0];
  assign M_Last = pipe_out[1];
`ifdef CONV_BIAS_RD_STATS_EN
  always_ff @(posedge clk or posedge rst)
    if (rst) Rd_Word_Cnt <= '0;
    else if (start_ok) Rd_Word_Cnt <= '0;
    else if (rd_en_fifo && ~&Rd_Word_Cnt) Rd_Word_Cnt <= Rd_Word_Cnt + 32'd1;
`endif
endmodule

// File: tb/tb_conv_bias_rd_ctrl.sv
// tb_conv_bias_rd_ctrl: vector table, directed stall/reset sequences and randomized layers vs a scoreboard
module tb_conv_bias_rd_ctrl;
  logic clk = 0, rst, Start, fifo_ready, M_Ready;
  logic [11:0] Row_Num_Out_REG, Col_Num_Out_REG;
  logic [9:0] Channel_Out_Num_REG;
  logic rd_en_fifo, M_Valid, M_Last, Busy, Done;
  logic [6:0] bias_addr;
`ifdef CONV_BIAS_RD_STATS_EN
  logic [31:0] Rd_Word_Cnt;
`endif
  always #5 clk = ~clk;

  conv_bias_rd_ctrl dut (
    .clk(clk), .rst(rst), .Start(Start),
    .Row_Num_Out_REG(Row_Num_Out_REG), .Col_Num_Out_REG(Col_Num_Out_REG),
    .Channel_Out_Num_REG(Channel_Out_Num_REG),
    .fifo_ready(fifo_ready), .M_Ready(M_Ready),
    .rd_en_fifo(rd_en_fifo), .bias_addr(bias_addr), .M_Valid(M_Valid),
    .M_Last(M_Last), .Busy(Busy), .Done(Done)
`ifdef CONV_BIAS_RD_STATS_EN
    , .Rd_Word_Cnt(Rd_Word_Cnt)
`endif
  );

  typedef struct {int row; int col; int chan; int reads; int done_cyc;} vec_t;
  vec_t tbl[8];
  int n_chk = 0, n_fail = 0;
  int cfg_row = 0, cfg_g = 0, cfg_tot = 0;
  int m_reads = 0, m_bursts = 0, m_run = 0;
  logic [3:1] vh = '0, lh = '0;
  logic prev_rd = 0, prev_ok = 0, prev_last = 0;
  logic s_rd, s_v, s_l, s_busy, s_done;
  logic [6:0] s_addr;
  int cyc;

  task automatic chk(string name, longint act, longint exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // scoreboard: delay line of rd_en, burst/address order, Done placement
  task automatic mon();
    s_rd = rd_en_fifo; s_addr = bias_addr; s_v = M_Valid; s_l = M_Last;
    s_busy = Busy; s_done = Done;
    if (rst) begin
      vh = '0; lh = '0; m_reads = 0; m_bursts = 0; m_run = 0;
      prev_rd = 0; prev_ok = 0; prev_last = 0;
      return;
    end
`ifdef CONV_BIAS_RD_STATS_EN
    chk("rd_word_cnt", Rd_Word_Cnt, m_reads);
`endif
    chk("m_valid", s_v, vh[3]);
    chk("m_last", s_l, lh[3]);
    if (s_done) begin
      chk("done_reads", m_reads, cfg_tot);
      if (cfg_tot != 0) chk("done_after_last", prev_last, 1);
    end
    if (Start && !s_busy) begin m_reads = 0; m_bursts = 0; end
    if (s_rd && !prev_rd) begin
      chk("burst_start_ready", prev_ok, 1);
      chk("burst_addr", s_addr, cfg_g != 0 ? m_bursts % cfg_g : 0);
      m_bursts++;
      m_run = 0;
    end
    if (s_rd) begin
      chk("addr_stable", s_addr, cfg_g != 0 ? (m_bursts - 1) % cfg_g : 0);
      m_run++;
    end
    if (!s_rd && prev_rd) chk("burst_len", m_run, cfg_row);
    lh = {lh[2:1], s_rd && (m_reads + 1 == cfg_tot)};
    vh = {vh[2:1], s_rd};
    if (s_rd) m_reads++;
    prev_rd = s_rd; prev_ok = fifo_ready && M_Ready; prev_last = s_l;
  endtask

  task automatic tick();
    @(negedge clk);
    mon();
    @(posedge clk);
    #2;
  endtask

  task automatic start_layer(int row, int col, int chan);
    Row_Num_Out_REG = 12'(row); Col_Num_Out_REG = 12'(col); Channel_Out_Num_REG = 10'(chan);
    cfg_row = row; cfg_g = chan >> 3; cfg_tot = row * col * cfg_g;
    Start = 1;
    tick();
    Start = 0;
  endtask

  task automatic wait_done(bit rnd, output int c);
    c = -1;
    for (int k = 1; k <= 3000; k++) begin
      if (rnd) begin
        fifo_ready = $urandom_range(0, 3) != 0;
        M_Ready = $urandom_range(0, 3) != 0;
        Start = $urandom_range(0, 9) == 0;
        Row_Num_Out_REG = 12'($urandom_range(0, 9));
        Channel_Out_Num_REG = 10'($urandom_range(0, 99));
      end
      tick();
      if (s_done) begin c = k; break; end
    end
    Start = 0; fifo_ready = 1; M_Ready = 1;
    if (c < 0) begin
      n_chk++; n_fail++;
      $display("FAIL done_timeout: got no Done expected Done within 3000 cycles");
    end
  endtask

  task automatic wait_rd(logic val);
    for (int k = 0; k < 200; k++) begin
      tick();
      if (s_rd === val) return;
    end
    n_chk++; n_fail++;
    $display("FAIL wait_rd_timeout: got no rd_en_fifo=%0d expected it within 200 cycles", val);
  endtask

  function automatic int exp_done(int row, int col, int chan);
    int b = (chan >> 3) * col;
    return (b == 0 || row == 0) ? 1 : 1 + (b - 1) * (row + 2) + row + 4;
  endfunction

  initial begin
    tbl[0] = '{4, 2, 16, 16, 27};
    tbl[1] = '{2, 1, 8, 2, 7};
    tbl[2] = '{4, 2, 4, 0, 1};
    tbl[3] = '{0, 3, 8, 0, 1};
    tbl[4] = '{5, 0, 16, 0, 1};
    tbl[5] = '{3, 2, 8, 6, 13};
    tbl[6] = '{1, 3, 24, 9, 30};
    tbl[7] = '{2, 2, 15, 4, 11};
    rst = 1; Start = 0; fifo_ready = 1; M_Ready = 1;
    Row_Num_Out_REG = '0; Col_Num_Out_REG = '0; Channel_Out_Num_REG = '0;
    repeat (2) @(posedge clk);
    #2;
    tick();
    chk("rst_rd_en", s_rd, 0); chk("rst_addr", s_addr, 0); chk("rst_mvalid", s_v, 0);
    chk("rst_mlast", s_l, 0); chk("rst_busy", s_busy, 0); chk("rst_done", s_done, 0);
    rst = 0;
    tick();
    foreach (tbl[i]) begin
      start_layer(tbl[i].row, tbl[i].col, tbl[i].chan);
      wait_done(0, cyc);
      chk("done_cycle", cyc, tbl[i].done_cyc);
      chk("total_reads", m_reads, tbl[i].reads);
`ifdef CONV_BIAS_RD_STATS_EN
      chk("stats_at_done", Rd_Word_Cnt, tbl[i].reads);
`endif
      tick();
      chk("done_one_cycle", s_done, 0);
      chk("idle_after_done", s_busy, 0);
    end
    // fifo_ready stall ahead of the second burst
    start_layer(4, 2, 16);
    wait_rd(1); wait_rd(0);
    fifo_ready = 0;
    for (int k = 0; k < 10; k++) begin
      tick();
      chk("stall_rd", s_rd, 0);
      chk("stall_addr", s_addr, 1);
    end
    fifo_ready = 1;
    tick(); chk("resume_wait", s_rd, 0);
    tick(); chk("resume_rd", s_rd, 1);
    wait_done(0, cyc);
    // M_Ready drop mid-burst does not cut the burst short
    start_layer(4, 2, 16);
    wait_rd(1);
    M_Ready = 0;
    begin
      int n = 1;
      for (int k = 0; k < 10; k++) begin
        tick();
        if (!s_rd) break;
        n++;
      end
      chk("burst_len_noready", n, 4);
    end
    for (int k = 0; k < 5; k++) begin tick(); chk("hold_noready", s_rd, 0); end
    M_Ready = 1;
    wait_done(0, cyc);
    // reset on the second word of the third burst
    start_layer(4, 2, 16);
    wait_rd(1); wait_rd(0); wait_rd(1); wait_rd(0); wait_rd(1);
    rst = 1;
    #1;
    chk("midrst_rd_en", rd_en_fifo, 0);
    chk("midrst_mvalid", M_Valid, 0);
    chk("midrst_busy", Busy, 0);
    tick();
    rst = 0;
    for (int k = 0; k < 6; k++) begin tick(); chk("no_done_after_rst", s_done, 0); end
    start_layer(2, 1, 8);
    wait_done(0, cyc);
    chk("post_rst_done_cycle", cyc, 7);
    chk("post_rst_reads", m_reads, 2);
    // random configs with ready tied high: exact completion time
    for (int t = 0; t < 10; t++) begin
      int r = $urandom_range(0, 6), c = $urandom_range(0, 3), ch = $urandom_range(0, 40);
      start_layer(r, c, ch);
      wait_done(0, cyc);
      chk("rand_done_cycle", cyc, exp_done(r, c, ch));
      tick();
    end
    // random configs with random stalls and ignored Start pulses
    for (int t = 0; t < 25; t++) begin
      start_layer($urandom_range(1, 6), $urandom_range(0, 3), $urandom_range(0, 40));
      wait_done(1, cyc);
      tick();
      chk("rand_idle_after_done", s_busy, 0);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
